// File: rtl/psola_playback.sv
// Ping-pong frame buffer that replays committed PSOLA frames at the sample rate.
// Define PSOLA_PLAYBACK_SAT_EN to saturate samples instead of wrapping them.
module psola_playback #(
  parameter int MAX_EXTENDED = 2200,
  parameter int HOLD_CYCLES  = 2304,
  parameter int SHIFT        = 10
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [31:0]                     psola_in,
  input  logic [$clog2(MAX_EXTENDED)-1:0] psola_addr_in,
  input  logic                            psola_valid_in,
  input  logic                            psola_done_in,
  output logic [15:0]                     sample_out,
  output logic                            sample_valid_out,
  output logic [15:0]                     underrun_count_out,
  output logic                            playing_out
);

  localparam int AW = $clog2(MAX_EXTENDED);
  localparam int LW = $clog2(MAX_EXTENDED + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    PLAY,
    STARVED
  } state_e;

  state_e        state_q, state_d;
  logic          wsel_q, wsel_d;
  logic          pend_q, pend_d;
  logic [LW-1:0] wr_len_q, wr_len_d;
  logic [LW-1:0] cmt_len_q, cmt_len_d;
  logic [LW-1:0] play_len_q, play_len_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]   urun_q, urun_d;
  logic [1:0]    vpipe_q, ppipe_q;
  logic [15:0]   sample_q;
  logic          svalid_q;

  logic [31:0]   buf0_q [MAX_EXTENDED];
  logic [31:0]   buf1_q [MAX_EXTENDED];
  logic [31:0]   rd1_q, rd2_q;

  logic          tick;
  logic          wr_ok;
  logic [LW-1:0] addr_p1;
  logic [LW-1:0] wr_len_upd;
  logic signed [31:0] shifted;
  logic [15:0]   conv;

  assign tick    = (hold_q == HW'(HOLD_CYCLES - 1));
  assign wr_ok   = psola_valid_in &&
                   (LW'(psola_addr_in) < LW'(MAX_EXTENDED));
  assign addr_p1 = LW'(psola_addr_in) + LW'(1);
  assign wr_len_upd = (wr_ok && (addr_p1 > wr_len_q)) ?
                      addr_p1 : wr_len_q;

  always_comb begin
    state_d    = state_q;
    wsel_d     = wsel_q;
    pend_d     = pend_q;
    wr_len_d   = wr_len_upd;
    cmt_len_d  = cmt_len_q;
    play_len_d = play_len_q;
    rd_addr_d  = rd_addr_q;
    urun_d     = urun_q;
    hold_d     = tick ? '0 : hold_q + HW'(1);
    if (psola_done_in && (wr_len_upd != '0)) begin
      pend_d    = 1'b1;
      cmt_len_d = wr_len_upd;
    end
    // A pending swap wins over end-of-frame, so no underrun is counted
    if (tick) begin
      if (pend_q) begin
        wsel_d     = ~wsel_q;
        play_len_d = cmt_len_q;
        rd_addr_d  = '0;
        wr_len_d   = '0;
        pend_d     = 1'b0;
        state_d    = PLAY;
      end else if (state_q == PLAY) begin
        if (LW'(rd_addr_q) == play_len_q - LW'(1)) begin
          state_d = STARVED;
          if (urun_q != 16'hffff) urun_d = urun_q + 16'd1;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
    end
  end

  always_comb begin
    shifted = $signed(rd2_q) >>> SHIFT;
    conv    = 16'(shifted);
`ifdef PSOLA_PLAYBACK_SAT_EN
    if (shifted > 32'sd32767) conv = 16'h7fff;
    else if (shifted < -32'sd32768) conv = 16'h8000;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= EMPTY;
      wsel_q     <= 1'b0;
      pend_q     <= 1'b0;
      wr_len_q   <= '0;
      cmt_len_q  <= '0;
      play_len_q <= '0;
      hold_q     <= '0;
      rd_addr_q  <= '0;
      urun_q     <= '0;
      vpipe_q    <= '0;
      ppipe_q    <= '0;
      sample_q   <= '0;
      svalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wsel_q     <= wsel_d;
      pend_q     <= pend_d;
      wr_len_q   <= wr_len_d;
      cmt_len_q  <= cmt_len_d;
      play_len_q <= play_len_d;
      hold_q     <= hold_d;
      rd_addr_q  <= rd_addr_d;
      urun_q     <= urun_d;
      vpipe_q    <= {vpipe_q[0], tick};
      ppipe_q    <= {ppipe_q[0], tick && (state_q == PLAY)};
      svalid_q   <= vpipe_q[1];
      if (vpipe_q[1]) sample_q <= ppipe_q[1] ? conv : 16'h0000;
    end
  end

  // Play buffer is the one not selected for writing
  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      if (wsel_q) buf1_q[psola_addr_in] <= psola_in;
      else        buf0_q[psola_addr_in] <= psola_in;
    end
    rd1_q <= wsel_q ? buf0_q[rd_addr_q] : buf1_q[rd_addr_q];
    rd2_q <= rd1_q;
  end

  assign sample_out         = sample_q;
  assign sample_valid_out   = svalid_q;
  assign underrun_count_out = urun_q;
  assign playing_out        = (state_q == PLAY);

endmodule

// File: tb/tb_psola_playback.sv
// Randomized bench for psola_playback against a frame-queue reference model.
// Build with or without PSOLA_PLAYBACK_SAT_EN; expectations follow the macro.
module tb_psola_playback;
  localparam int MAXE = 12;
  localparam int HOLD = 8;
  localparam int SH   = 10;
  localparam int AW   = $clog2(MAXE);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [31:0]   psola_in = '0;
  logic [AW-1:0] psola_addr_in = '0;
  logic          psola_valid_in = 1'b0;
  logic          psola_done_in = 1'b0;
  logic [15:0]   sample_out;
  logic          sample_valid_out;
  logic [15:0]   underrun_count_out;
  logic          playing_out;

  int checks = 0;
  int errors = 0;

  psola_playback #(
    .MAX_EXTENDED(MAXE),
    .HOLD_CYCLES (HOLD),
    .SHIFT       (SH)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .psola_in          (psola_in),
    .psola_addr_in     (psola_addr_in),
    .psola_valid_in    (psola_valid_in),
    .psola_done_in     (psola_done_in),
    .sample_out        (sample_out),
    .sample_valid_out  (sample_valid_out),
    .underrun_count_out(underrun_count_out),
    .playing_out       (playing_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] conv(input logic [31:0] w);
    longint s;
    s = longint'($signed(w));
    s = s >>> SH;
`ifdef PSOLA_PLAYBACK_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Reference model: committed frames become a queue of words to play
  int          m_hc = 0;
  int          m_cyc = 0;
  int          m_wlen = 0;
  int          m_clen = 0;
  bit          m_pend = 0;
  logic        m_play = 0;
  logic [15:0] m_urun = 0;
  logic [15:0] m_last = 0;
  logic [31:0] wf [MAXE];
  logic [31:0] play_q [$];
  int          due_q [$];
  logic [15:0] val_q [$];
  bit          tag_q [$];
  logic [15:0] play_obs [$];
  int          zero_seen = 0;

  always @(posedge clk_in or negedge rst_in) begin : model
    bit          tk;
    logic [15:0] v;
    logic [31:0] w;
    if (!rst_in) begin
      m_hc = 0; m_cyc = 0; m_wlen = 0; m_clen = 0;
      m_pend = 0; m_play = 0; m_urun = 0; m_last = 0;
      play_q.delete(); due_q.delete();
      val_q.delete(); tag_q.delete();
    end else begin
      m_cyc++;
      tk = (m_hc == HOLD - 1);
      m_hc = tk ? 0 : m_hc + 1;
      if (tk) begin
        v = 16'h0000;
        if (m_play) begin
          w = play_q.pop_front();
          v = conv(w);
        end
        due_q.push_back(m_cyc + 2);
        val_q.push_back(v);
        tag_q.push_back(m_play);
        if (m_pend) begin
          play_q.delete();
          for (int i = 0; i < m_clen; i++) play_q.push_back(wf[i]);
          m_play = 1; m_pend = 0; m_wlen = 0;
        end else if (m_play && play_q.size() == 0) begin
          m_play = 0;
          if (m_urun != 16'hffff) m_urun = m_urun + 16'd1;
        end
      end
      if (psola_valid_in && int'(psola_addr_in) < MAXE) begin
        wf[psola_addr_in] = psola_in;
        if (int'(psola_addr_in) + 1 > m_wlen)
          m_wlen = int'(psola_addr_in) + 1;
      end
      if (psola_done_in && m_wlen > 0) begin
        m_pend = 1;
        m_clen = m_wlen;
      end
    end
  end

  always @(negedge clk_in) begin : monitor
    int          d;
    logic [15:0] v;
    bit          t;
    if (rst_in) begin
      if (sample_valid_out) begin
        checks++;
        if (due_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got %h at cycle %0d, none due",
                   sample_out, m_cyc);
        end else begin
          d = due_q.pop_front();
          v = val_q.pop_front();
          t = tag_q.pop_front();
          if (d != m_cyc || sample_out !== v) begin
            errors++;
            $display("FAIL sample: got %h at cycle %0d, want %h at cycle %0d",
                     sample_out, m_cyc, v, d);
          end
          m_last = v;
          if (t) play_obs.push_back(sample_out);
          else if (sample_out === 16'h0000) zero_seen++;
        end
      end else begin
        if (due_q.size() > 0 && due_q[0] <= m_cyc) begin
          checks++;
          errors++;
          $display("FAIL sample_missing: no valid at cycle %0d, want %h",
                   m_cyc, val_q[0]);
          void'(due_q.pop_front());
          m_last = val_q.pop_front();
          void'(tag_q.pop_front());
        end
        checks++;
        if (sample_out !== m_last) begin
          errors++;
          $display("FAIL sample_stable: got %h want %h", sample_out, m_last);
        end
      end
      checks++;
      if (underrun_count_out !== m_urun) begin
        errors++;
        $display("FAIL underrun: got %0d want %0d", underrun_count_out, m_urun);
      end
      checks++;
      if (playing_out !== m_play) begin
        errors++;
        $display("FAIL playing: got %b want %b", playing_out, m_play);
      end
    end
  end

  task automatic safe_edge();
    @(negedge clk_in);
    while (m_hc == HOLD - 1) @(negedge clk_in);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit dn);
    safe_edge();
    psola_addr_in  = AW'(a);
    psola_in       = d;
    psola_valid_in = 1'b1;
    psola_done_in  = dn;
    @(negedge clk_in);
    psola_valid_in = 1'b0;
    psola_done_in  = 1'b0;
  endtask

  task automatic done_pulse();
    safe_edge();
    psola_done_in = 1'b1;
    @(negedge clk_in);
    psola_done_in = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * HOLD) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    play_obs.delete();
    zero_seen = 0;
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (sample_out !== 16'h0) begin
      errors++; $display("FAIL reset_sample: got %h want 0", sample_out);
    end
    checks++;
    if (sample_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", sample_valid_out);
    end
    checks++;
    if (underrun_count_out !== 16'h0) begin
      errors++; $display("FAIL reset_underrun: got %0d want 0", underrun_count_out);
    end
    checks++;
    if (playing_out !== 1'b0) begin
      errors++; $display("FAIL reset_playing: got %b want 0", playing_out);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] want [4];
    want = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_reset();
    wr(0, 32'h400, 0);
    wr(1, 32'h800, 0);
    wr(2, 32'hc00, 0);
    wr(3, 32'h1000, 1);
    wait_ticks(8);
    checks++;
    if (play_obs.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d want 4", play_obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (play_obs[i] !== want[i]) begin
          errors++;
          $display("FAIL basic_word%0d: got %h want %h", i, play_obs[i], want[i]);
        end
      end
    end
    checks++;
    if (underrun_count_out !== 16'd1) begin
      errors++; $display("FAIL basic_underrun: got %0d want 1", underrun_count_out);
    end
    checks++;
    if (playing_out !== 1'b0) begin
      errors++; $display("FAIL basic_starved: got %b want 0", playing_out);
    end
  endtask

  task automatic test_empty_done();
    do_reset();
    done_pulse();
    wait_ticks(3);
    checks++;
    if (playing_out !== 1'b0) begin
      errors++; $display("FAIL empty_playing: got %b want 0", playing_out);
    end
    checks++;
    if (play_obs.size() != 0 || zero_seen < 2) begin
      errors++;
      $display("FAIL empty_samples: played %0d zeros %0d, want 0 and >=2",
               play_obs.size(), zero_seen);
    end
  endtask

  task automatic test_restart();
    logic [31:0] b [2];
    do_reset();
    for (int i = 0; i < 8; i++) wr(i, $urandom, 0);
    done_pulse();
    wait_ticks(3);
    b[0] = $urandom;
    b[1] = $urandom;
    wr(0, b[0], 0);
    wr(1, b[1], 0);
    done_pulse();
    wait_ticks(1);
    checks++;
    if (underrun_count_out !== 16'd0 || playing_out !== 1'b1) begin
      errors++;
      $display("FAIL restart_swap: underrun %0d playing %b, want 0 and 1",
               underrun_count_out, playing_out);
    end
    wait_ticks(4);
    checks++;
    if (play_obs.size() < 2) begin
      errors++; $display("FAIL restart_count: got %0d want >=2", play_obs.size());
    end else if (play_obs[$-1] !== conv(b[0]) || play_obs[$] !== conv(b[1])) begin
      errors++;
      $display("FAIL restart_words: got %h %h want %h %h", play_obs[$-1],
               play_obs[$], conv(b[0]), conv(b[1]));
    end
    checks++;
    if (underrun_count_out !== 16'd1) begin
      errors++; $display("FAIL restart_underrun: got %0d want 1", underrun_count_out);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] e0, e1;
`ifdef PSOLA_PLAYBACK_SAT_EN
    e0 = 16'h7fff; e1 = 16'h8000;
`else
    e0 = 16'hffff; e1 = 16'h0000;
`endif
    do_reset();
    wr(0, 32'h7fffffff, 0);
    wr(1, 32'h80000000, 1);
    wait_ticks(5);
    checks++;
    if (play_obs.size() != 2) begin
      errors++; $display("FAIL sat_count: got %0d want 2", play_obs.size());
    end else begin
      checks++;
      if (play_obs[0] !== e0 || play_obs[1] !== e1) begin
        errors++;
        $display("FAIL sat_words: got %h %h want %h %h",
                 play_obs[0], play_obs[1], e0, e1);
      end
    end
  endtask

  task automatic test_oob();
    do_reset();
    wr(MAXE, 32'h0bad0000, 0);
    wr(0, 32'h00012c00, 0);
    done_pulse();
    wait_ticks(4);
    checks++;
    if (play_obs.size() != 1) begin
      errors++; $display("FAIL oob_len: got %0d want 1", play_obs.size());
    end else begin
      checks++;
      if (play_obs[0] !== 16'h004b) begin
        errors++; $display("FAIL oob_word: got %h want 004b", play_obs[0]);
      end
    end
    checks++;
    if (underrun_count_out !== 16'd1) begin
      errors++; $display("FAIL oob_underrun: got %0d want 1", underrun_count_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(0, 32'h2000, 1);
    wait_ticks(4);
    for (int i = 0; i < 8; i++) wr(i, 32'h4000 + 32'(i) * 32'h400, 0);
    done_pulse();
    wait_ticks(3);
    checks++;
    if (playing_out !== 1'b1 || underrun_count_out !== 16'd1) begin
      errors++;
      $display("FAIL midrst_pre: playing %b underrun %0d, want 1 and 1",
               playing_out, underrun_count_out);
    end
    for (int i = 0; i < 3; i++) wr(i, 32'h1234000, 0);
    done_pulse();
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if (sample_out !== 16'h0 || sample_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_sample: got %h/%b want 0/0",
               sample_out, sample_valid_out);
    end
    checks++;
    if (playing_out !== 1'b0 || underrun_count_out !== 16'h0) begin
      errors++;
      $display("FAIL midrst_state: playing %b underrun %0d, want 0 and 0",
               playing_out, underrun_count_out);
    end
    play_obs.delete();
    @(negedge clk_in);
    rst_in = 1'b1;
    wait_ticks(3);
    checks++;
    if (playing_out !== 1'b0 || play_obs.size() != 0) begin
      errors++;
      $display("FAIL midrst_discard: playing %b played %0d, want 0 and 0",
               playing_out, play_obs.size());
    end
  endtask

  task automatic test_random();
    int perm [MAXE];
    int len, j, t;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(MAXE, 1);
      for (int i = 0; i < len; i++) perm[i] = i;
      for (int i = len - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0)
          wr($urandom_range(2 ** AW - 1, MAXE), $urandom, 0);
        wr(perm[i], $urandom, 0);
      end
      done_pulse();
      wait_ticks(1 + $urandom_range(len + 2, 0));
    end
    wait_ticks(MAXE + 2);
    checks++;
    if (due_q.size() != 0) begin
      errors++; $display("FAIL random_drain: %0d samples outstanding, want 0",
                         due_q.size());
    end
    checks++;
    if (underrun_count_out !== m_urun || playing_out !== 1'b0) begin
      errors++;
      $display("FAIL random_end: underrun %0d playing %b, want %0d and 0",
               underrun_count_out, playing_out, m_urun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_done();
    test_restart();
    test_saturate();
    test_oob();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psola_playback.md
PSOLA_PLAYBACK -- requirements
Module: psola_playback

Interface
REQ-001 SHALL have parameter MAX_EXTENDED, default 2200, the maximum frame length in samples per buffer.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2304, the clocks per output sample period (about 43.4 kHz at 100 MHz).
REQ-003 SHALL have parameter SHIFT, default 10, the right-shift applied to 32-bit PSOLA words before output.
REQ-004 SHALL have port clk_in, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port psola_in, input, 32 bits: signed PSOLA output word.
REQ-007 SHALL have port psola_addr_in, input, $clog2(MAX_EXTENDED) bits: write address within the current frame.
REQ-008 SHALL have port psola_valid_in, input, 1 bit: write strobe.
REQ-009 SHALL have port psola_done_in, input, 1 bit: one-cycle pulse marking the current frame complete.
REQ-010 SHALL have port sample_out, output, 16 bits: signed sample for the PDM stage.
REQ-011 SHALL have port sample_valid_out, output, 1 bit: one-cycle pulse when sample_out updates.
REQ-012 SHALL have port underrun_count_out, output, 16 bits: count of starvation events.
REQ-013 SHALL have port playing_out, output, 1 bit: high in state PLAY.

Function
REQ-014 SHALL hold two internal ping-pong buffers of MAX_EXTENDED x 32 bits, one being written and one being played; write_sel selects the write buffer.
REQ-015 SHALL write psola_in at psola_addr_in into the write buffer when psola_valid_in is high and psola_addr_in < MAX_EXTENDED; out-of-range writes are dropped.
REQ-016 SHALL track wr_len as the highest accepted address + 1 since the last commit.
REQ-017 SHALL, on psola_done_in with wr_len > 0, set a pending-commit flag that latches wr_len as the frame length; a done pulse with wr_len == 0 is ignored.
REQ-018 SHALL include a write on the same cycle as psola_done_in in the committed frame.
REQ-019 SHALL run a free-running hold counter 0..HOLD_CYCLES-1 and generate a tick when it wraps.
REQ-020 SHALL, at a tick with commit pending, perform the swap: toggle write_sel, set play length to the latched length, reset read address to 0, clear wr_len and pending, and enter PLAY.
REQ-021 SHALL make a second done pulse before the swap replace the latched length; the commit stays pending and only one swap occurs.
REQ-022 SHALL implement states EMPTY (reset; outputs 0 per tick), PLAY (read play buffer at the read address, which increments per tick), and STARVED (outputs 0 per tick).
REQ-023 SHALL transition PLAY -> STARVED at the tick after read address reaches play length - 1, incrementing underrun_count_out (saturating at 0xFFFF) once per entry.
REQ-024 SHALL transition EMPTY or STARVED -> PLAY only via the swap in REQ-020; a swap in PLAY restarts at address 0 without counting an underrun.
REQ-025 SHALL derive each PLAY output sample as the 32-bit word arithmetically right-shifted by SHIFT and reduced to 16 bits per REQ-031/032.
REQ-026 SHALL pulse sample_valid_out and update sample_out exactly 3 cycles after each tick (RAM read 2 cycles, output register 1 cycle) in every state.
REQ-027 SHALL keep sample_out stable between updates.

Reset
REQ-028 SHALL, while rst_in is low, immediately clear state to EMPTY and zero sample_out, sample_valid_out, underrun_count_out, playing_out, write_sel, wr_len, the pending flag, the hold counter, and the read address.
REQ-029 SHALL leave buffer contents undefined after reset; they are never played before a commit.
REQ-030 SHALL, on reset mid-frame, discard any partially written or pending frame.

Configuration
REQ-031 SHALL, with PSOLA_PLAYBACK_SAT_EN defined, saturate the shifted value to the range -32768..32767.
REQ-032 SHALL, with PSOLA_PLAYBACK_SAT_EN undefined, truncate the shifted value to its low 16 bits (wrap).

Verification
REQ-033 SHALL cover this case: HOLD_CYCLES=8; write addresses 0..3 with values 0x400, 0x800, 0xC00, 0x1000, then done -> after the next tick, outputs 1, 2, 3, 4, each 3 cycles after its tick, then 0 values and underrun_count_out=1.
REQ-034 SHALL cover this case: done with no writes -> state stays EMPTY, no swap, all output samples 0.
REQ-035 SHALL cover this case: second frame of length 2 committed while the first is mid-play -> at the next tick, playback restarts at address 0 of the new buffer with underrun_count_out unchanged.
REQ-036 SHALL cover this case: word 0x7FFFFFFF with SHIFT=10 -> sample_out=0x7FFF with PSOLA_PLAYBACK_SAT_EN defined, 0xFFFF without it.
REQ-037 SHALL cover this case: write to address MAX_EXTENDED plus one valid write at address 0, then done -> frame length is 1, and the out-of-range word is never played.
REQ-038 SHALL cover this case: rst_in pulled low during PLAY between clock edges -> outputs zero before the next edge, state EMPTY, underrun_count_out=0.
